// File: rtl/bus_xfer_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
package bus_xfer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        LATCH = ST_LATCH
    } xfer_state_t;

    // Bits needed to index n registers (minimum 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bus_transfer_ctrl_onehot_decoder.sv
// Enabled index-to-one-hot decoder; all zeros when disabled.
module onehot_decoder #(
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic              i_en,
    input  logic [IDXW-1:0]   i_idx,
    output logic [NREGS-1:0]  o_dec
);

    // Out-of-range indices simply decode to zero.
    always_comb begin
        o_dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            o_dec[i] = i_en && (i_idx == i[IDXW-1:0]);
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-to-register move sequencer: IDLE -> DRIVE -> LATCH.
// Optional immediate path enabled by macro BUS_XFER_IMM_EN.
module bus_transfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int IDXW  = idx_width(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDXW-1:0]   req_src,
    input  logic [IDXW-1:0]   req_dst,
`ifdef BUS_XFER_IMM_EN
    input  logic              req_imm,
    input  logic [WIDTH-1:0]  imm_data,
    output logic [WIDTH-1:0]  bus_out,
`endif
    output logic [NREGS-1:0]  oe,
    output logic [NREGS-1:0]  ld,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [IDXW:0] NREGS_W = (IDXW+1)'(NREGS);

    if (NREGS < 2 || WIDTH < 1) begin : g_param_check
        $error("bus_transfer_ctrl: NREGS must be >= 2 and WIDTH >= 1");
    end

    xfer_state_t        r_state, w_next;
    logic [IDXW-1:0]    r_src, r_dst;
    logic [NREGS-1:0]   r_oe, r_ld, w_oe_dec, w_ld_dec;
    logic               r_done, r_err;
    logic               w_accept, w_legal, w_req_imm, w_imm_next;
    logic               w_src_ok, w_dst_ok;
    logic [IDXW-1:0]    w_oe_idx;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_src_ok = {1'b0, req_src} < NREGS_W;
    assign w_dst_ok = {1'b0, req_dst} < NREGS_W;
    // Immediate moves have no source register, so only dst is checked.
    assign w_legal  = w_dst_ok && (w_req_imm || (w_src_ok && (req_src != req_dst)));

`ifdef BUS_XFER_IMM_EN
    logic               r_imm;
    logic [WIDTH-1:0]   r_data;

    assign w_req_imm  = req_imm;
    assign w_imm_next = (r_state == IDLE) ? req_imm : r_imm;
    assign bus_out    = (r_imm && (r_state != IDLE)) ? r_data : {WIDTH{1'bz}};

    // Capture immediate payload on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_imm  <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_imm  <= req_imm;
            r_data <= imm_data;
        end
    end
`else
    assign w_req_imm  = 1'b0;
    assign w_imm_next = 1'b0;
`endif

    // Next-state logic; illegal requests retire straight from IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_legal) w_next = DRIVE;
            DRIVE:   w_next = LATCH;
            LATCH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so the
    // source index comes straight from the request on the accept edge.
    assign w_oe_idx = (r_state == IDLE) ? req_src : r_src;

    onehot_decoder #(.NREGS(NREGS), .IDXW(IDXW)) u_oe_dec (
        .i_en  ((w_next != IDLE) && !w_imm_next),
        .i_idx (w_oe_idx),
        .o_dec (w_oe_dec)
    );

    onehot_decoder #(.NREGS(NREGS), .IDXW(IDXW)) u_ld_dec (
        .i_en  (w_next == LATCH),
        .i_idx (r_dst),
        .o_dec (w_ld_dec)
    );

    // State, strobe and completion registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_oe    <= '0;
            r_ld    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_oe    <= w_oe_dec;
            r_ld    <= w_ld_dec;
            r_done  <= (r_state == LATCH) || (w_accept && !w_legal);
            r_err   <= w_accept && !w_legal;
        end
    end

    // Request index capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
        end else if (w_accept) begin
            r_src <= req_src;
            r_dst <= req_dst;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign oe        = r_oe;
    assign ld        = r_ld;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl (8-register and 6-register builds).
`timescale 1ns/1ps
module tb_bus_transfer_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    always #5 clock = ~clock;

    logic       req_valid;
    logic [2:0] req_src, req_dst;
    logic       req_imm = 1'b0;
    logic [7:0] imm_data = 8'h00;
    logic       req_ready, busy, done, err;
    logic [7:0] oe, ld;
`ifdef BUS_XFER_IMM_EN
    logic [7:0] bus_out;
`endif

    bus_transfer_ctrl #(.WIDTH(8), .NREGS(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst),
`ifdef BUS_XFER_IMM_EN
        .req_imm(req_imm), .imm_data(imm_data), .bus_out(bus_out),
`endif
        .oe(oe), .ld(ld), .busy(busy), .done(done), .err(err)
    );

    logic       v6;
    logic [2:0] s6, d6;
    logic       r6, busy6, done6, err6;
    logic [5:0] oe6, ld6;
`ifdef BUS_XFER_IMM_EN
    logic [7:0] bus6;
`endif

    bus_transfer_ctrl #(.WIDTH(8), .NREGS(6)) dut6 (
        .clock(clock), .reset(reset), .req_valid(v6), .req_ready(r6),
        .req_src(s6), .req_dst(d6),
`ifdef BUS_XFER_IMM_EN
        .req_imm(1'b0), .imm_data(8'h00), .bus_out(bus6),
`endif
        .oe(oe6), .ld(ld6), .busy(busy6), .done(done6), .err(err6)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: age = cycles since the last accepted request.
    int         age = 0;
    bit         m_legal = 1'b0, m_imm = 1'b0;
    int         m_src = 0, m_dst = 0;
    logic [7:0] m_data = 8'h00;

    function automatic bit m_ready();
        return (age == 0) || (age >= 3) || !m_legal;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            age <= 0;
        end else if (req_valid && m_ready()) begin
            age     <= 1;
            m_src   <= int'(req_src);
            m_dst   <= int'(req_dst);
            m_imm   <= req_imm;
            m_data  <= imm_data;
            m_legal <= req_imm || (req_src != req_dst);
        end else if (age > 0 && age < 10) begin
            age <= age + 1;
        end
    end

    int cyc = 0;
    int done_q[$];
    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        logic [7:0] e_oe, e_ld;
        logic       e_done, e_err;
        bit         act12;
        act12  = m_legal && (age == 1 || age == 2);
        e_oe   = (act12 && !m_imm) ? 8'(1 << m_src) : 8'h00;
        e_ld   = (m_legal && age == 2) ? 8'(1 << m_dst) : 8'h00;
        e_done = (m_legal && age == 3) || (!m_legal && age == 1);
        e_err  = !m_legal && age == 1;
        chk("m_oe", 32'(oe), 32'(e_oe));
        chk("m_ld", 32'(ld), 32'(e_ld));
        chk("m_done", 32'(done), 32'(e_done));
        chk("m_err", 32'(err), 32'(e_err));
        chk("m_ready", 32'(req_ready), 32'(m_ready()));
        chk("m_busy", 32'(busy), 32'(!m_ready()));
        chk("onehot0_oe", 32'($onehot0(oe)), 32'd1);
        chk("onehot0_ld", 32'($onehot0(ld)), 32'd1);
`ifdef BUS_XFER_IMM_EN
        chk("m_bus", {24'h0, bus_out}, {24'h0, (act12 && m_imm) ? m_data : 8'hzz});
`endif
        if (done) done_q.push_back(cyc);
    end

    task automatic send(input int s, input int d, input bit imm, input logic [7:0] data, input bit hold);
        int n;
        req_src   = 3'(s);
        req_dst   = 3'(d);
        req_imm   = imm;
        imm_data  = data;
        req_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clock);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic send6(input int s, input int d);
        s6 = 3'(s);
        d6 = 3'(d);
        v6 = 1'b1;
        @(posedge clock);
        #1;
        v6 = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0;
        v6 = 1'b0; s6 = 3'd0; d6 = 3'd0;
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_oe", 32'(oe), 32'h00);
        chk("rst_ld", 32'(ld), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef BUS_XFER_IMM_EN
        chk("rst_bus", {24'h0, bus_out}, {24'h0, 8'hzz});
`endif
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // 2 -> 5
        send(2, 5, 1'b0, 8'h00, 1'b0);
        @(negedge clock); chk("t1_c1_oe", 32'(oe), 32'h04); chk("t1_c1_ld", 32'(ld), 32'h00);
        @(negedge clock); chk("t1_c2_oe", 32'(oe), 32'h04); chk("t1_c2_ld", 32'(ld), 32'h20);
        @(negedge clock); chk("t1_c3_done", 32'(done), 32'd1); chk("t1_c3_err", 32'(err), 32'd0);
        chk("t1_c3_oe", 32'(oe), 32'h00);
        @(posedge clock); #1;

        // back-to-back 1 -> 3, 3 -> 0 with valid held
        done_q.delete();
        send(1, 3, 1'b0, 8'h00, 1'b1);
        send(3, 0, 1'b0, 8'h00, 1'b0);
        repeat (4) @(negedge clock);
        chk("b2b_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() >= 2) chk("b2b_gap", 32'(done_q[1] - done_q[0]), 32'd3);
        @(posedge clock); #1;

        // src == dst
        send(4, 4, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        chk("eq_done", 32'(done), 32'd1); chk("eq_err", 32'(err), 32'd1);
        chk("eq_oe", 32'(oe), 32'h00); chk("eq_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;

        // six-register build: out-of-range src, out-of-range dst, legal 0 -> 5
        send6(7, 0);
        @(negedge clock);
        chk("n6_src7_done", 32'(done6), 32'd1); chk("n6_src7_err", 32'(err6), 32'd1);
        chk("n6_src7_oe", 32'(oe6), 32'h00); chk("n6_src7_ld", 32'(ld6), 32'h00);
        @(posedge clock); #1;
        send6(1, 6);
        @(negedge clock);
        chk("n6_dst6_err", 32'(err6), 32'd1); chk("n6_dst6_oe", 32'(oe6), 32'h00);
        @(posedge clock); #1;
        send6(0, 5);
        @(negedge clock); chk("n6_c1_oe", 32'(oe6), 32'h01); chk("n6_c1_ld", 32'(ld6), 32'h00);
        @(negedge clock); chk("n6_c2_oe", 32'(oe6), 32'h01); chk("n6_c2_ld", 32'(ld6), 32'h20);
        @(negedge clock); chk("n6_c3_done", 32'(done6), 32'd1); chk("n6_c3_err", 32'(err6), 32'd0);
        @(posedge clock); #1;

        // reset during LATCH of 0 -> 6
        send(0, 6, 1'b0, 8'h00, 1'b0);
        @(posedge clock); #2;
        chk("rl_pre_oe", 32'(oe), 32'h01); chk("rl_pre_ld", 32'(ld), 32'h40);
        reset = 1'b1;
        #1;
        chk("rl_oe", 32'(oe), 32'h00); chk("rl_ld", 32'(ld), 32'h00);
        chk("rl_ready", 32'(req_ready), 32'd1);
        @(negedge clock); #1 reset = 1'b0;
        n = 0;
        repeat (4) begin @(negedge clock); if (done) n++; end
        chk("rl_no_done", 32'(n), 32'd0);
        @(posedge clock); #1;

`ifdef BUS_XFER_IMM_EN
        // immediate 0xA5 -> 7
        send(0, 7, 1'b1, 8'hA5, 1'b0);
        @(negedge clock);
        chk("im_c1_bus", {24'h0, bus_out}, 32'hA5); chk("im_c1_oe", 32'(oe), 32'h00);
        chk("im_c1_ld", 32'(ld), 32'h00);
        @(negedge clock);
        chk("im_c2_bus", {24'h0, bus_out}, 32'hA5); chk("im_c2_oe", 32'(oe), 32'h00);
        chk("im_c2_ld", 32'(ld), 32'h80);
        @(negedge clock);
        chk("im_c3_bus", {24'h0, bus_out}, {24'h0, 8'hzz}); chk("im_c3_done", 32'(done), 32'd1);
        @(posedge clock); #1;
`endif

        // random stress
        for (int k = 0; k < 1000; k++) begin
            bit hold, imm;
            hold = 1'($urandom_range(0, 1));
`ifdef BUS_XFER_IMM_EN
            imm = ($urandom_range(0, 3) == 0);
`else
            imm = 1'b0;
`endif
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm,
                 8'($urandom_range(0, 255)), hold);
            if (!hold && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
